// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: shared definitions for the reg_alu sequencer and datapath.
// Holds the instruction class encodings, instruction field bit positions,
// the sequencer FSM state type, and the data/address width constants.
package reg_alu_pkg;

  localparam int unsigned DataWidth  = 16;
  localparam int unsigned AddrWidth  = 3;
  localparam int unsigned OpWidth    = 2;
  localparam int unsigned CountWidth = 8;

  // Instruction class, instr[15:14]
  typedef enum logic [1:0] {
    ClsNop   = 2'b00,
    ClsLoadi = 2'b01,
    ClsAlu   = 2'b10,
    ClsHalt  = 2'b11
  } instr_cls_e;

  // Field bit positions
  localparam int unsigned ClsMsb  = 15;
  localparam int unsigned ClsLsb  = 14;
  localparam int unsigned OpMsb   = 13;
  localparam int unsigned OpLsb   = 12;
  localparam int unsigned RaMsb   = 11;
  localparam int unsigned RaLsb   = 9;
  localparam int unsigned RbMsb   = 8;
  localparam int unsigned RbLsb   = 6;
  localparam int unsigned RdMsb   = 5;
  localparam int unsigned RdLsb   = 3;
  localparam int unsigned LdRdMsb = 2;
  localparam int unsigned LdRdLsb = 0;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StImm    = 2'b01,
    StIssue  = 2'b10,
    StHalted = 2'b11
  } state_e;

  function automatic instr_cls_e instr_cls(input logic [DataWidth-1:0] w);
    return instr_cls_e'(w[ClsMsb:ClsLsb]);
  endfunction

  function automatic logic [OpWidth-1:0] field_op(input logic [DataWidth-1:0] w);
    return w[OpMsb:OpLsb];
  endfunction

  function automatic logic [AddrWidth-1:0] field_ra(input logic [DataWidth-1:0] w);
    return w[RaMsb:RaLsb];
  endfunction

  function automatic logic [AddrWidth-1:0] field_rb(input logic [DataWidth-1:0] w);
    return w[RbMsb:RbLsb];
  endfunction

  function automatic logic [AddrWidth-1:0] field_rd(input logic [DataWidth-1:0] w);
    return w[RdMsb:RdLsb];
  endfunction

  function automatic logic [AddrWidth-1:0] field_ld_rd(input logic [DataWidth-1:0] w);
    return w[LdRdMsb:LdRdLsb];
  endfunction

endpackage

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: instruction sequencer driving a reg_alu register file / ALU.
// Accepts 16-bit words over a valid/ready handshake, decodes NOP / LOADI /
// ALU / HALT, and issues one register-file write per LOADI or ALU instruction.
//
// Ports:
//   clk, reset            sole clock, synchronous active-high reset
//   instr_valid/ready     word handshake; instr is the word
//   cout                  carry from the downstream ALU
//   sel, wr, op           write-data select, write strobe, ALU opcode
//   rd_addr_a/b, wr_addr  register-file addresses
//   d_in                  immediate write data
//   carry_flag            last captured ALU carry
//   halted                HALT retired
//   instr_count           retired-instruction counter (wraps)
//
// All outputs are registered. The write strobe and its address/data fields are
// loaded at the edge that ends the ISSUE cycle, so a word accepted at edge N
// produces wr high from edge N+1 to N+2, and a reset during ISSUE cancels it.
module reg_alu_seq
  import reg_alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [DataWidth-1:0]  instr,
  input  logic                  cout,
  output logic                  sel,
  output logic                  wr,
  output logic [OpWidth-1:0]    op,
  output logic [AddrWidth-1:0]  rd_addr_a,
  output logic [AddrWidth-1:0]  rd_addr_b,
  output logic [AddrWidth-1:0]  wr_addr,
  output logic [DataWidth-1:0]  d_in,
  output logic                  carry_flag,
  output logic                  halted,
  output logic [CountWidth-1:0] instr_count
);

  state_e r_state;
  state_e w_state_next;

  // Pending instruction captured at acceptance, retired at end of ISSUE
  logic                 r_pend_alu;
  logic [OpWidth-1:0]   r_pend_op;
  logic [AddrWidth-1:0] r_pend_ra;
  logic [AddrWidth-1:0] r_pend_rb;
  logic [AddrWidth-1:0] r_pend_rd;
  logic [DataWidth-1:0] r_pend_imm;

  // Output registers
  logic                  r_ready;
  logic                  r_sel;
  logic                  r_wr;
  logic [OpWidth-1:0]    r_op;
  logic [AddrWidth-1:0]  r_rd_addr_a;
  logic [AddrWidth-1:0]  r_rd_addr_b;
  logic [AddrWidth-1:0]  r_wr_addr;
  logic [DataWidth-1:0]  r_d_in;
  logic                  r_carry;
  logic                  r_halted;
  logic [CountWidth-1:0] r_count;

  logic       w_accept;
  instr_cls_e w_cls;
  logic       w_idle_accept;
  logic       w_issue;
  logic       w_count_inc;

  // r_ready mirrors the state (IDLE/IMM), so it doubles as the handshake gate
  assign w_accept      = instr_valid & r_ready;
  assign w_cls         = instr_cls(instr);
  assign w_idle_accept = w_accept & (r_state == StIdle);
  assign w_issue       = (r_state == StIssue);
  assign w_count_inc   = w_issue |
                         (w_idle_accept & ((w_cls == ClsNop) | (w_cls == ClsHalt)));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          unique case (w_cls)
            ClsNop:   w_state_next = StIdle;
            ClsLoadi: w_state_next = StImm;
            ClsAlu:   w_state_next = StIssue;
            ClsHalt:  w_state_next = StHalted;
          endcase
        end
      end
      // The word after LOADI is always data, whatever its class bits say
      StImm:    if (w_accept) w_state_next = StIssue;
      StIssue:  w_state_next = StIdle;
      StHalted: w_state_next = StHalted;
      default:  w_state_next = StIdle;
    endcase
  end

  // Pending-instruction capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_alu <= 1'b0;
      r_pend_op  <= '0;
      r_pend_ra  <= '0;
      r_pend_rb  <= '0;
      r_pend_rd  <= '0;
      r_pend_imm <= '0;
    end else if (w_accept) begin
      if (r_state == StImm) begin
        r_pend_imm <= instr;
      end else if (w_cls == ClsAlu) begin
        r_pend_alu <= 1'b1;
        r_pend_op  <= field_op(instr);
        r_pend_ra  <= field_ra(instr);
        r_pend_rb  <= field_rb(instr);
        r_pend_rd  <= field_rd(instr);
      end else if (w_cls == ClsLoadi) begin
        r_pend_alu <= 1'b0;
        r_pend_rd  <= field_ld_rd(instr);
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready     <= 1'b1;
      r_sel       <= 1'b0;
      r_wr        <= 1'b0;
      r_op        <= '0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_wr_addr   <= '0;
      r_d_in      <= '0;
      r_carry     <= 1'b0;
      r_halted    <= 1'b0;
      r_count     <= '0;
    end else begin
      r_ready  <= (w_state_next == StIdle) | (w_state_next == StImm);
      r_halted <= (w_state_next == StHalted);
      r_wr     <= w_issue;
      if (w_issue) begin
        r_wr_addr <= r_pend_rd;
        if (r_pend_alu) begin
          r_sel       <= 1'b1;
          r_op        <= r_pend_op;
          r_rd_addr_a <= r_pend_ra;
          r_rd_addr_b <= r_pend_rb;
          r_carry     <= cout;
        end else begin
          r_sel  <= 1'b0;
          r_d_in <= r_pend_imm;
        end
      end
      if (w_count_inc) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign instr_ready = r_ready;
  assign sel         = r_sel;
  assign wr          = r_wr;
  assign op          = r_op;
  assign rd_addr_a   = r_rd_addr_a;
  assign rd_addr_b   = r_rd_addr_b;
  assign wr_addr     = r_wr_addr;
  assign d_in        = r_d_in;
  assign carry_flag  = r_carry;
  assign halted      = r_halted;
  assign instr_count = r_count;

endmodule

// File: tb/tb_reg_alu_seq.sv
// Self-checking bench for reg_alu_seq: a cycle table of directed vectors
// followed by hand-written reset and counter-wrap sequences. cout is driven
// directly as stimulus standing in for the downstream ALU carry.
module tb_reg_alu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic        cout = 1'b0;
  logic        sel;
  logic        wr;
  logic [1:0]  op;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [2:0]  wr_addr;
  logic [15:0] d_in;
  logic        carry_flag;
  logic        halted;
  logic [7:0]  instr_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_alu_seq dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .cout        (cout),
    .sel         (sel),
    .wr          (wr),
    .op          (op),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .wr_addr     (wr_addr),
    .d_in        (d_in),
    .carry_flag  (carry_flag),
    .halted      (halted),
    .instr_count (instr_count)
  );

  // {ready, wr, sel, op, a, b, wa, d_in, carry, halted, count}
  logic [39:0] obs;
  assign obs = {instr_ready, wr, sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
                carry_flag, halted, instr_count};

  function automatic logic [39:0] e(input logic rdy, input logic w, input logic s,
                                    input logic [1:0] o, input logic [2:0] a,
                                    input logic [2:0] b, input logic [2:0] wa,
                                    input logic [15:0] d, input logic c,
                                    input logic h, input logic [7:0] n);
    return {rdy, w, s, o, a, b, wa, d, c, h, n};
  endfunction

  typedef struct {
    logic        v;
    logic [15:0] w;
    logic        c;
    logic [39:0] x;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [15:0] w, input logic c,
                     input logic [39:0] x);
    vec_t t;
    t.v = v; t.w = w; t.c = c; t.x = x;
    tbl.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] w, input logic c);
    instr_valid = v;
    instr       = w;
    cout        = c;
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0000, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  localparam logic [39:0] Zero = 40'h80_0000_0000;  // ready=1, everything else 0

  initial begin
    logic wr_seen;

    // ready, wr, sel, op, a, b, wa, d_in, carry, halted, count
    add(1, 16'h4003, 0, e(1,0,0,0,0,0,0,16'h0000,0,0,0));  // LOADI r3
    add(1, 16'hcdef, 0, e(0,0,0,0,0,0,0,16'h0000,0,0,0));  // immediate
    add(0, 16'h0000, 0, e(1,1,0,0,0,0,3,16'hcdef,0,0,1));  // write r3
    add(0, 16'h0000, 0, e(1,0,0,0,0,0,3,16'hcdef,0,0,1));
    add(1, 16'h4001, 0, e(1,0,0,0,0,0,3,16'hcdef,0,0,1));  // LOADI r1
    add(0, 16'h0000, 0, e(1,0,0,0,0,0,3,16'hcdef,0,0,1));  // IMM waits
    add(1, 16'hba98, 0, e(0,0,0,0,0,0,3,16'hcdef,0,0,1));
    add(0, 16'h0000, 0, e(1,1,0,0,0,0,1,16'hba98,0,0,2));
    add(1, 16'h4005, 0, e(1,0,0,0,0,0,1,16'hba98,0,0,2));  // LOADI r5
    add(1, 16'h4567, 0, e(0,0,0,0,0,0,1,16'hba98,0,0,2));
    add(0, 16'h0000, 0, e(1,1,0,0,0,0,5,16'h4567,0,0,3));
    add(1, 16'h8350, 0, e(0,0,0,0,0,0,5,16'h4567,0,0,3));  // ALU 0 r2=r1,r5
    add(0, 16'h0000, 0, e(1,1,1,0,1,5,2,16'h4567,0,0,4));
    add(1, 16'hbfa0, 0, e(0,0,1,0,1,5,2,16'h4567,0,0,4));  // ALU 3 r4=r7,r6
    add(0, 16'h0000, 1, e(1,1,1,3,7,6,4,16'h4567,1,0,5));  // carry captured
    add(1, 16'h4000, 0, e(1,0,1,3,7,6,4,16'h4567,1,0,5));  // LOADI r0
    add(1, 16'h1234, 0, e(0,0,1,3,7,6,4,16'h4567,1,0,5));
    add(0, 16'h0000, 0, e(1,1,0,3,7,6,0,16'h1234,1,0,6));  // carry held
    add(1, 16'h0000, 0, e(1,0,0,3,7,6,0,16'h1234,1,0,7));  // NOP
    add(1, 16'h8350, 0, e(0,0,0,3,7,6,0,16'h1234,1,0,7));  // back-to-back
    add(1, 16'h8350, 0, e(1,1,1,0,1,5,2,16'h1234,0,0,8));
    add(1, 16'hbfa0, 0, e(0,0,1,0,1,5,2,16'h1234,0,0,8));
    add(1, 16'hbfa0, 1, e(1,1,1,3,7,6,4,16'h1234,1,0,9));
    add(1, 16'h4006, 0, e(1,0,1,3,7,6,4,16'h1234,1,0,9));  // LOADI r6
    add(1, 16'hc0de, 0, e(0,0,1,3,7,6,4,16'h1234,1,0,9));  // HALT bits = data
    add(0, 16'h0000, 0, e(1,1,0,3,7,6,6,16'hc0de,1,0,10));
    add(1, 16'hc000, 0, e(0,0,0,3,7,6,6,16'hc0de,1,1,11)); // HALT
    add(1, 16'h0000, 0, e(0,0,0,3,7,6,6,16'hc0de,1,1,11)); // ignored
    add(1, 16'h8350, 1, e(0,0,0,3,7,6,6,16'hc0de,1,1,11)); // ignored

    reset = 1'b1;
    step();
    step();
    check("reset_state", obs, Zero);
    reset = 1'b0;
    step();
    check("first_cycle_after_reset", obs, Zero);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].c);
      step();
      check($sformatf("vec%0d", i), obs, tbl[i].x);
    end

    // Reset leaves HALTED
    do_reset();
    check("reset_from_halted", obs, Zero);

    // Reset in IMM with a simultaneous handshake drops both words
    drive(1'b1, 16'h4007, 1'b0);
    step();
    reset = 1'b1;
    drive(1'b1, 16'h8350, 1'b0);
    step();
    reset = 1'b0;
    check("reset_in_imm", obs, Zero);
    drive(1'b1, 16'h8350, 1'b0);
    step();
    check("after_imm_reset_accept", obs, e(0,0,0,0,0,0,0,16'h0000,0,0,0));
    drive(1'b0, 16'h0000, 1'b0);
    step();
    check("after_imm_reset_decoded", obs, e(1,1,1,0,1,5,2,16'h0000,0,0,1));

    // Reset in ISSUE cancels the write and the count
    do_reset();
    drive(1'b1, 16'hbfa0, 1'b1);
    step();
    reset = 1'b1;
    drive(1'b0, 16'h0000, 1'b1);
    step();
    reset = 1'b0;
    check("reset_in_issue", obs, Zero);
    step();
    check("reset_in_issue_no_pulse", obs, Zero);

    // 256 NOPs wrap the counter without any write
    do_reset();
    wr_seen = 1'b0;
    drive(1'b1, 16'h0000, 1'b0);
    for (int n = 1; n <= 256; n++) begin
      step();
      if (wr !== 1'b0) wr_seen = 1'b1;
      if (n == 255) check("nop_count_255", {32'd0, instr_count}, 40'd255);
    end
    check("nop_count_wrap", obs, Zero);
    check("nop_no_wr", {39'd0, wr_seen}, 40'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_alu_seq.md
REG_ALU_SEQ -- requirements
Module: reg_alu_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
- clk  in  1  rising-edge clock, sole clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  upstream word available
- instr_ready  out  1  block accepts word this cycle
- instr  in  16  instruction or immediate word
- cout  in  1  carry from downstream reg_alu
- sel  out  1  0 = write d_in, 1 = write ALU result
- wr  out  1  register-file write strobe
- op  out  2  ALU opcode
- rd_addr_a  out  3  read port A address
- rd_addr_b  out  3  read port B address
- wr_addr  out  3  write address
- d_in  out  16  immediate write data
- carry_flag  out  1  last captured ALU carry
- halted  out  1  HALT retired
- instr_count  out  8  retired-instruction counter

Function
REQ-002 A word SHALL be accepted on a rising edge where instr_valid=1 and instr_ready=1.
REQ-003 Instruction encoding SHALL be as follows.
- instr[15:14]: 00 NOP, 01 LOADI, 10 ALU, 11 HALT
- ALU fields: op=[13:12], ra=[11:9], rb=[8:6], rd=[5:3]
- LOADI fields: rd=[2:0]; the next accepted word is the 16-bit immediate
REQ-004 The FSM SHALL have the states IDLE, IMM, ISSUE and HALTED, with encodings held in the package.
REQ-005 instr_ready SHALL be 1 in IDLE and IMM, and 0 in ISSUE and HALTED.
REQ-006 IDLE transitions SHALL be as follows.
- NOP accepted: stay in IDLE
- LOADI accepted: go to IMM, latch rd
- ALU accepted: go to ISSUE
- HALT accepted: go to HALTED
REQ-007 In IMM, an accepted word SHALL be taken as the immediate regardless of its [15:14] bits, and the FSM SHALL go to ISSUE.
REQ-008 ISSUE SHALL last exactly one cycle, then return to IDLE; HALTED SHALL be left only by reset.
REQ-009 All outputs SHALL be registered.
- During ISSUE: wr=1.
- In every other state: wr=0, and sel/op/addresses/d_in hold their last values.
REQ-010 An ALU issue SHALL drive the following.
- sel=1, op=op field
- rd_addr_a=ra, rd_addr_b=rb, wr_addr=rd
- d_in unchanged
REQ-011 A LOADI issue SHALL drive sel=0, wr_addr=rd, d_in=immediate, with op and read addresses unchanged.
REQ-012 Latency: for a word accepted at edge N, wr SHALL be high between edges N+1 and N+2.
REQ-013 Throughput SHALL be at most one ALU instruction per 2 cycles and one LOADI per 3 cycles.
REQ-014 carry_flag SHALL load cout at the clock edge that ends an ALU ISSUE cycle, and hold otherwise; LOADI SHALL NOT change it.
REQ-015 instr_count SHALL increment by 1 in the following cases, and wrap 255->0.
- at the end of each ISSUE cycle
- on NOP acceptance
- on HALT acceptance
- LOADI counts once, not per word
REQ-016 halted SHALL equal 1 exactly when the FSM is in HALTED.
REQ-017 instr_valid=0 in IMM SHALL hold IMM indefinitely with no timeout.

Reset
REQ-018 While reset=1 at an edge, the block SHALL enter IDLE and clear every output register to 0: sel, wr, op, addresses, d_in, carry_flag, halted, instr_count.
REQ-019 instr_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-020 Reset asserted in IMM or ISSUE SHALL discard the pending instruction: no wr pulse and no count increment.
REQ-021 Reset SHALL take priority over a simultaneous handshake, and the word presented in that cycle SHALL be dropped.

Structure
REQ-022 The shared package reg_alu_pkg SHALL hold the following.
- instruction class encodings
- field bit positions
- FSM state typedef/encodings
- the data width constant (16)
- the address width constant (3)
REQ-023 The block SHALL be a single module with no sub-module.
REQ-024 The integration bench SHALL connect reg_alu_seq outputs directly to a reg_alu instance on the same clk and reset.

Verification
REQ-025 LOADI r3, then word 16'hcdef -> wr high for one cycle after the second acceptance with sel=0, wr_addr=3, d_in=cdef; instr_count=1.
REQ-026 ALU op=00, ra=1, rb=5, rd=2 after loading r1=ba98 and r5=4567 -> ISSUE drives sel=1, op=00, a=1, b=5, wr_addr=2; carry_flag=0; instr_count increments.
REQ-027 Valid held high with ALU words back-to-back -> instr_ready alternates 1/0 and exactly one wr pulse per instruction.
REQ-028 Reset asserted in IMM after accepting LOADI r7 -> no wr pulse; state IDLE; all outputs 0; the next word is decoded as an instruction.
REQ-029 HALT accepted -> halted=1 and instr_ready=0; further valid words are ignored until reset.
REQ-030 256 NOPs -> instr_count wraps to 0 with wr never asserted.
